pcihellocore_keyport_capture: RTL
=================================

PCIHELLOCORE_KEYPORT_CAPTURE -- requirements
Module: pcihellocore_keyport_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 18: number of input bits, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before a change is accepted; 0 bypasses debounce.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: edge captured, 0 rising, 1 falling, 2 any.
REQ-004 SHALL have parameter INIT_LEVEL, default 0: reset level of the synchronizer and debounced bits, replicated across all bits.
REQ-005 SHALL have a single clock, clk (input, 1): rising-edge clock for all state.
REQ-006 SHALL have reset_n (input, 1): asynchronous, active-low reset.
REQ-007 SHALL have address (input, 2): Avalon-MM slave word address.
REQ-008 SHALL have chipselect (input, 1): slave select.
REQ-009 SHALL have write_n (input, 1): active-low write strobe.
REQ-010 SHALL have writedata (input, 32): write data.
REQ-011 SHALL have readdata (output, 32): read data.
REQ-012 SHALL have in_port (input, WIDTH): asynchronous external inputs (switches/keys).
REQ-013 SHALL have irq (output, 1): level interrupt request.

Function
REQ-014 SHALL synchronize each in_port bit through two flops before any other use.
REQ-015 SHALL debounce each bit: per-bit counter increments while sync bit differs from debounced bit and clears when equal; the debounced bit takes the sync value on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-016 SHALL give latency of exactly 2+DEBOUNCE_CYCLES clk edges from an in_port change (held stable) to the debounced bit change; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL cause no change.
REQ-017 SHALL set edgecapture[i] on the same edge debounced[i] changes in the direction selected by EDGE_TYPE.
REQ-018 SHALL use the map: address 0 debounced data (RO); 1 irqmask (R/W, WIDTH bits); 2 edgecapture (read; write-1-to-clear); 3 reserved, reads 0, writes ignored.
REQ-019 SHALL perform a write only when chipselect=1 and write_n=0, taking effect on that clk edge.
REQ-020 SHALL drive readdata combinationally from address with zero wait states, unused upper bits 0, independent of chipselect.
REQ-021 SHALL give priority to set when a new edge and a write-1-to-clear hit the same bit on the same edge; the bit remains 1.
REQ-022 SHALL drive irq = OR of (edgecapture AND irqmask), combinational from registers.
REQ-023 SHALL ignore writes to address 0 and writes to bits at or above WIDTH.

Reset
REQ-024 SHALL, on reset_n=0, immediately set sync flops and debounced bits to INIT_LEVEL, all counters to 0, irqmask to 0 and edgecapture to 0; irq SHALL therefore be 0.
REQ-025 SHALL produce no edge capture from the reset value itself or from reset release.
REQ-026 SHALL abort any debounce count in progress on reset mid-operation, with no partial update.

Structure
REQ-027 SHALL place register address constants (DATA=0, MASK=1, EDGE=2) and the EDGE_TYPE encodings in shared package pcihellocore_pio_pkg.
REQ-028 SHALL implement synchronizer, counter and debounced flop per bit in sub-module pcihellocore_debounce_bit, instantiated WIDTH times; counter width = clog2(DEBOUNCE_CYCLES+1).
REQ-029 SHALL keep edge detection, registers and read mux in the top module.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated)
REQ-030 SHALL verify reset: assert reset_n mid-count -> address 0/1/2 read 0, irq=0, and no edge appears after release.
REQ-031 SHALL verify latency: in_port 0000->0101 held -> address 0 reads 0x5 exactly 6 edges later, edgecapture=0x5, irq=0 with mask 0.
REQ-032 SHALL verify glitch rejection: bit0 high for 3 cycles then low -> data and edgecapture stay 0.
REQ-033 SHALL verify irq: mask=0x1, edge on bit0 -> irq=1; write 0x1 to address 2 -> edgecapture 0, irq=0 next cycle.
REQ-034 SHALL verify set-over-clear: bit2 edge on the same edge as a write of 0x4 to address 2 -> edgecapture[2]=1.
REQ-035 SHALL verify edge types: with EDGE_TYPE=1, 1->0 captured and 0->1 not; with EDGE_TYPE=2, both captured; address 3 reads 0.

Source files
------------

// File: rtl/pcihellocore_pio_pkg.sv
// Shared constants for the keyport capture PIO: register word addresses and
// the encodings for which debounced transitions raise an edge capture.
package pcihellocore_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only lets the debounced level follow after DEBOUNCE_CYCLES steady cycles.
module pcihellocore_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic debounced,
    output logic changing
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_meta;
    logic          sync_bit;
    logic [CW-1:0] count;

    // High on the edge where the debounced level is about to flip, so the
    // parent can record the transition on that very same edge.
    assign changing = (sync_bit != debounced) &&
                      ((int'(count) + 1) >= DEBOUNCE_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= INIT_LEVEL;
            sync_bit  <= INIT_LEVEL;
            debounced <= INIT_LEVEL;
            count     <= '0;
        end else begin
            sync_meta <= in_bit;
            sync_bit  <= sync_meta;
            if (sync_bit == debounced) begin
                count <= '0;
            end else if (changing) begin
                debounced <= sync_bit;
                count     <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcihellocore_keyport_capture.sv
// Avalon-MM PIO for switches/keys: debounced data, interrupt mask and a
// sticky edge-capture register whose masked OR drives a level interrupt.
module pcihellocore_keyport_capture
    import pcihellocore_pio_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter int INIT_LEVEL      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] changing;
    logic [WIDTH-1:0] new_edges;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic             write_en;
    logic             unused_writedata;

    assign unused_writedata = &{1'b0, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_LEVEL     (INIT_LEVEL != 0)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .debounced(debounced[i]),
            .changing (changing[i])
        );
    end

    // The old debounced value tells us the direction of a pending flip.
    always_comb begin
        new_edges = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  new_edges = changing & ~debounced;
            EDGE_FALLING: new_edges = changing & debounced;
            default:      new_edges = changing;
        endcase
    end

    assign write_en   = chipselect && !write_n;
    assign edge_clear = (write_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a simultaneous set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (write_en && address == ADDR_MASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~edge_clear) | new_edges;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = debounced;
            ADDR_MASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGE: readdata[WIDTH-1:0] = edgecapture;
            default:   readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule
